sha256_msg_feeder: RTL and testbench

- Supply side of the sha256_update word interface.
- Accepts message words from a valid/ready stream (AXI-side writer) and stores them in a two-bank (ping-pong) 16-word block buffer.
- Issues one update pulse per 512-bit block and serves the core's block_offset word requests with exactly one cycle of read latency.
- Tracks done pulses and flags when the final digest on hash0..hash7 is valid. One bank fills while the other is being hashed.

---
 rtl/sha256_msg_feeder_pkg.sv | 16 +
 rtl/sha256_block_bank.sv | 47 ++++
 rtl/sha256_msg_feeder.sv | 152 +++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_feeder_pkg.sv
// Shared constants and hash-side state encoding for the SHA-256 message feeder.
package sha256_msg_feeder_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned IDX_W = 4;

  // One-hot, matching the core's state style.
  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StIssue = 5'b00010,
    StWait  = 5'b00100,
    StRel   = 5'b01000,
    StGap   = 5'b10000
  } hstate_e;

endpackage

// File: rtl/sha256_block_bank.sv
// Two 16-word block banks with per-bank full flags, one write port and a registered read port.
module sha256_block_bank
  import sha256_msg_feeder_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              set_full,
  input  logic              set_bank,
  input  logic              clr_full,
  input  logic              clr_bank,
  input  logic              rd_bank,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [1:0]        full
);

  logic [WORD_W-1:0] mem_q [2][WORDS_PER_BLOCK];
  logic [1:0]        full_q;
  logic [WORD_W-1:0] rd_data_q;

  // Released banks are cleared so a short close already reads as zero-filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      full_q    <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_bank][rd_idx];
      if (wr_en) mem_q[wr_bank][wr_idx] <= wr_data;
      if (clr_full) begin
        mem_q[clr_bank]  <= '{default: '0};
        full_q[clr_bank] <= 1'b0;
      end
      if (set_full) full_q[set_bank] <= 1'b1;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;

endmodule

// File: rtl/sha256_msg_feeder.sv
// Feeds message words from a valid/ready stream into a ping-pong block buffer for sha256_update.
module sha256_msg_feeder
  import sha256_msg_feeder_pkg::*;
#(
  parameter int unsigned MSG_SIZE_W = 64,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MSG_SIZE_W-1:0] msg_size,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [WORD_W-1:0]     upd_w,
  input  logic [IDX_W-1:0]      upd_offset,
  output logic                  upd_update,
  output logic                  upd_en,
  output logic                  upd_reset,
  output logic [MSG_SIZE_W-1:0] upd_msg_size,
  input  logic                  upd_done,
  output logic                  busy,
  output logic                  hash_valid,
  output logic                  err_short
);

  hstate_e               state_q, state_d;
  logic [MSG_SIZE_W-1:0] msg_size_q, tot_words_q, words_in_q;
  logic [IDX_W-1:0]      fill_idx_q;
  logic                  fill_bank_q, hash_bank_q;
  logic                  busy_q, en_q, upd_reset_q, fill_done_q, zero_pend_q, err_short_q;
  logic [1:0]            full;

  logic start_acc, xfer, last_word, short_last, zero_close, close, done_close;
  logic clr_full, rel_last;

  always_comb begin
    start_acc  = start & ~busy_q;
    s_ready    = busy_q & ~full[fill_bank_q] & ~fill_done_q & (words_in_q < tot_words_q);
    xfer       = s_valid & s_ready;
    last_word  = (words_in_q + MSG_SIZE_W'(1)) == tot_words_q;
    short_last = xfer & s_last & ~last_word;
    zero_close = busy_q & zero_pend_q & ~full[fill_bank_q];
    close      = (xfer & ((fill_idx_q == IDX_W'(WORDS_PER_BLOCK - 1)) | last_word | s_last))
               | zero_close;
    done_close = (xfer & (last_word | s_last)) | zero_close;
  end

  always_comb begin
    state_d  = state_q;
    clr_full = 1'b0;
    rel_last = 1'b0;
    unique case (state_q)
      StIdle:  if (busy_q && full[hash_bank_q]) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (upd_done) state_d = StRel;
      StRel: begin
        clr_full = 1'b1;
        // Last block: fill side is finished and nothing is queued in the other bank.
        rel_last = fill_done_q & ~full[~hash_bank_q];
        state_d  = rel_last ? StIdle : StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_size_q  <= '0;
      tot_words_q <= '0;
      words_in_q  <= '0;
      fill_idx_q  <= '0;
      fill_bank_q <= 1'b0;
      hash_bank_q <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      upd_reset_q <= 1'b0;
      fill_done_q <= 1'b0;
      zero_pend_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      upd_reset_q <= start_acc;
      if (start_acc) begin
        msg_size_q  <= msg_size;
        tot_words_q <= (msg_size >> 5) + MSG_SIZE_W'(|msg_size[4:0]);
        words_in_q  <= '0;
        fill_idx_q  <= '0;
        fill_bank_q <= 1'b0;
        hash_bank_q <= 1'b0;
        busy_q      <= 1'b1;
        en_q        <= 1'b1;
        fill_done_q <= 1'b0;
        zero_pend_q <= (msg_size == '0);
        err_short_q <= 1'b0;
      end else begin
        if (xfer) begin
          words_in_q <= words_in_q + MSG_SIZE_W'(1);
          fill_idx_q <= fill_idx_q + IDX_W'(1);
        end
        if (close) begin
          fill_bank_q <= ~fill_bank_q;
          fill_idx_q  <= '0;
        end
        if (done_close) begin
          fill_done_q <= 1'b1;
          zero_pend_q <= 1'b0;
        end
        if (short_last) err_short_q <= 1'b1;
        if (clr_full) hash_bank_q <= ~hash_bank_q;
        if (rel_last) begin
          busy_q <= 1'b0;
          en_q   <= 1'b0;
        end
      end
    end
  end

  sha256_block_bank #(
    .WORD_W(WORD_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (xfer),
    .wr_bank  (fill_bank_q),
    .wr_idx   (fill_idx_q),
    .wr_data  (s_data),
    .set_full (close),
    .set_bank (fill_bank_q),
    .clr_full (clr_full),
    .clr_bank (hash_bank_q),
    .rd_bank  (hash_bank_q),
    .rd_idx   (upd_offset),
    .rd_data  (upd_w),
    .full     (full)
  );

  assign upd_update   = (state_q == StIssue);
  assign hash_valid   = rel_last;
  assign upd_en       = en_q;
  assign upd_reset    = reset | upd_reset_q;
  assign upd_msg_size = msg_size_q;
  assign busy         = busy_q;
  assign err_short    = err_short_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Directed bench for sha256_msg_feeder; the bench itself plays the sha256_update core.
module tb_sha256_msg_feeder;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_ready, s_last;
  logic [63:0] msg_size, upd_msg_size;
  logic [31:0] s_data, upd_w;
  logic [3:0]  upd_offset;
  logic        upd_update, upd_en, upd_reset, upd_done, busy, hash_valid, err_short;

  sha256_msg_feeder #(
    .MSG_SIZE_W(64),
    .WORD_W    (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .msg_size     (msg_size),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_last       (s_last),
    .upd_w        (upd_w),
    .upd_offset   (upd_offset),
    .upd_update   (upd_update),
    .upd_en       (upd_en),
    .upd_reset    (upd_reset),
    .upd_msg_size (upd_msg_size),
    .upd_done     (upd_done),
    .busy         (busy),
    .hash_valid   (hash_valid),
    .err_short    (err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] msg;
    int          beats;
    logic [31:0] base;
    logic        err;
    int          upd;
    int          stalls;  // -1: not checked
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc = 0, hv_cnt = 0, upd_cnt = 0, xfer_cnt = 0, stalls = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hash_valid) hv_cnt = hv_cnt + 1;
    if (upd_update) upd_cnt = upd_cnt + 1;
    if (s_valid && s_ready) xfer_cnt = xfer_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] beat_data(input vec_t v, input int k);
    return v.base + 32'(k) * 32'h01010101;
  endfunction

  function automatic logic [31:0] exp_word(input vec_t v, input int idx);
    return (idx < v.beats) ? beat_data(v, idx) : 32'h0;
  endfunction

  task automatic producer(input vec_t v);
    int guard;
    stalls = 0;
    for (int k = 0; k < v.beats; k++) begin
      s_valid = 1'b1;
      s_data  = beat_data(v, k);
      s_last  = (k == v.beats - 1);
      guard   = 0;
      while (!s_ready && guard < 500) begin
        stalls++;
        guard++;
        tick();
      end
      if (guard >= 500) begin
        chk("prod_ready_timeout", s_ready, 1);
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (v.err) begin
      s_valid = 1'b1;
      s_data  = 32'hdeadbeef;
      for (int i = 0; i < 4; i++) begin
        chk("ready_after_short", s_ready, 0);
        tick();
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic core(input vec_t v);
    int guard;
    int done_cyc;
    done_cyc = -100;
    tick();
    chk("upd_reset_pulse_end", upd_reset, 0);
    chk("upd_en_on", upd_en, 1);
    for (int u = 0; u < v.upd; u++) begin
      guard = 0;
      while (!upd_update && guard < 400) begin
        guard++;
        tick();
      end
      chk("upd_seen", upd_update, 1);
      if (u > 0) chk("upd_gap", (cyc - done_cyc) >= 4, 1);
      // Dropped start and a stray done while not yet waiting.
      start    = 1'b1;
      msg_size = v.msg + 64'd7;
      upd_done = 1'b1;
      tick();
      start    = 1'b0;
      msg_size = v.msg;
      upd_done = 1'b0;
      chk("upd_one_cycle", upd_update, 0);
      // Two passes emulate the core's padding-overflow re-read of the frozen bank.
      for (int p = 0; p < 2; p++) begin
        for (int o = 0; o < 16; o++) begin
          upd_offset = 4'(o);
          tick();
          chk($sformatf("upd_w u%0d p%0d o%0d", u, p, o), upd_w, exp_word(v, u * 16 + o));
        end
      end
      chk("hv_before_done", hash_valid, 0);
      upd_done = 1'b1;
      done_cyc = cyc;
      tick();
      upd_done = 1'b0;
      chk("hash_valid_timing", hash_valid, (u == v.upd - 1));
    end
  endtask

  task automatic run_msg(input vec_t v);
    hv_cnt   = 0;
    upd_cnt  = 0;
    xfer_cnt = 0;
    msg_size = v.msg;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_upd_reset", upd_reset, 1);
    chk("start_err_clear", err_short, 0);
    fork
      producer(v);
      core(v);
    join
    tick();
    chk("end_busy", busy, 0);
    chk("end_upd_en", upd_en, 0);
    repeat (6) tick();
    chk("err_short", err_short, v.err);
    chk("upd_count", upd_cnt, v.upd);
    chk("hv_count", hv_cnt, 1);
    chk("xfer_count", xfer_cnt, v.beats);
    chk("msg_size_latched", upd_msg_size, v.msg);
    if (v.stalls >= 0) chk("stalls", stalls, v.stalls);
  endtask

  vec_t vecs[8];

  initial begin
    int guard;
    vecs[0] = '{msg: 64'd24,   beats: 1,  base: 32'h61626300, err: 1'b0, upd: 1, stalls: 0};
    vecs[1] = '{msg: 64'd448,  beats: 14, base: 32'h10000000, err: 1'b0, upd: 1, stalls: 0};
    vecs[2] = '{msg: 64'd1024, beats: 32, base: 32'h20000000, err: 1'b0, upd: 2, stalls: 0};
    vecs[3] = '{msg: 64'd0,    beats: 0,  base: 32'h0,        err: 1'b0, upd: 1, stalls: 0};
    vecs[4] = '{msg: 64'd96,   beats: 2,  base: 32'h30000000, err: 1'b1, upd: 1, stalls: 0};
    vecs[5] = '{msg: 64'd512,  beats: 16, base: 32'h40000000, err: 1'b0, upd: 1, stalls: 0};
    vecs[6] = '{msg: 64'd544,  beats: 17, base: 32'h50000000, err: 1'b0, upd: 2, stalls: 0};
    vecs[7] = '{msg: 64'd1536, beats: 48, base: 32'h60000000, err: 1'b0, upd: 3, stalls: -1};

    reset = 1'b1; start = 1'b0; msg_size = '0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    upd_offset = '0; upd_done = 1'b0;
    tick();
    tick();
    chk("rst_upd_reset", upd_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_upd_update", upd_update, 0);
    chk("rst_hash_valid", hash_valid, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_upd_en", upd_en, 0);
    chk("rst_upd_w", upd_w, 0);
    chk("rst_msg_size", upd_msg_size, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_upd_reset", upd_reset, 0);

    for (int i = 0; i < 8; i++) run_msg(vecs[i]);

    // Reset while the core is hashing: aborts without hash_valid and empties the banks.
    hv_cnt   = 0;
    msg_size = 64'd24;
    start    = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h61626300;
    s_last  = 1'b1;
    guard   = 0;
    while (!s_ready && guard < 50) begin
      guard++;
      tick();
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    guard   = 0;
    while (!upd_update && guard < 50) begin
      guard++;
      tick();
    end
    chk("abort_upd_seen", upd_update, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_upd_reset", upd_reset, 1);
    reset      = 1'b0;
    upd_offset = 4'd0;
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_upd_en", upd_en, 0);
    tick();
    chk("abort_bank_empty", upd_w, 0);
    repeat (4) tick();
    chk("abort_no_hv", hv_cnt, 0);
    chk("abort_no_update", upd_update, 0);
    run_msg(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
